uart_tx_io: RTL
===============

// Module: uart_tx_io
// PURPOSE
//  Memory-mapped UART transmitter peripheral downstream of the MemOrIO address decoder.
//  CPU stores bytes to the data register; the block queues them in a FIFO and serialises 8N1, LSB first, on tx.
//  CPU loads the status register to poll busy/full/empty/overflow. Runs in the cpu_clk domain.
// PARAMETERS
//  CLK_HZ      23_000_000  input clock frequency (Hz)
//  BAUD        115_200     line rate; DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 2
//  FIFO_DEPTH  16          byte entries, power of two, >= 2
// PORTS
//  clk      in   1   cpu_clk
//  rstn     in   1   asynchronous active-low reset
//  uart_cs  in   1   chip select from MemOrIO (address in UART window)
//  io_write in   1   store strobe, qualified by uart_cs
//  io_read  in   1   load strobe, qualified by uart_cs
//  addr_lo  in   2   register offset: 0 = DATA (write-only), 1 = STATUS (read-only)
//  wdata    in   8   byte to transmit (r_rdata[7:0])
//  rdata    out  32  read data, combinational from registered state
//  tx       out  1   serial line, idle high
// BEHAVIOUR
//  Reset: tx=1, FIFO empty, count=0, overflow=0, FSM IDLE, baud counter 0, bit index 0; rdata follows state (STATUS=0x0000_0004).
//  Push: cs&io_write&addr_lo==0 at a rising edge pushes wdata.
//   Accepted if count<DEPTH, or if count==DEPTH and a pop occurs the same edge.
//   Otherwise byte dropped, overflow<=1.
//  Writes to offset 1/2/3 ignored. Reads of offset 0/2/3 return 0.
//  STATUS rdata: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow,
//   [8:4] count (zero-extended to DEPTH width+1), rest 0.
//  Overflow sticky; cleared on the edge of a STATUS read (cs&io_read&addr_lo==1).
//   A same-edge overflow event wins (stays 1).
//  FSM IDLE->START: when FIFO non-empty; pop head into shift reg; tx<=0 on that edge; baud cnt<=0.
//  START: hold tx=0 for DIV cycles, then DATA with tx<=shift[0].
//  DATA: each bit held DIV cycles; shift right; after bit 7's DIV cycles -> STOP, tx<=1.
//  STOP: hold tx=1 for DIV cycles.
//   Then IDLE and, if FIFO non-empty, immediately start the next frame on the same edge (no idle gap).
//  Frame = exactly 10*DIV cycles; back-to-back frames contiguous.
//  Baud counter counts 0..DIV-1, wraps at bit boundary; only runs outside IDLE.
//  FIFO pointers wrap modulo DEPTH; count is DEPTH-width+1 bits, never exceeds DEPTH.
//  Push into empty FIFO while IDLE: frame starts on the next edge (tx falls 1 cycle after the store edge).
//  Reset mid-frame: tx returns to 1 asynchronously, FIFO contents discarded; no partial frame resumes.
//  Glitch-free tx: driven from a flop, never from combinational logic.
// STRUCTURE
//  Shared header uart_defs.vh: UART_DATA_OFS=2'd0, UART_STAT_OFS=2'd1, status bit indices,
//   FSM encodings S_IDLE/S_START/S_DATA/S_STOP (2-bit).
//  Sub-module uart_tx_fifo: synchronous-write, show-ahead FIFO.
//   Ports: push/pop/din/dout/count/full/empty; same-edge push+pop when full permitted.
//  Top holds FSM, baud counter, shift register, overflow flag, rdata mux.
// TESTING  (CLK_HZ=1_152_000, BAUD=115_200 -> DIV=10)
//  Reset: hold rstn=0 -> tx=1, STATUS read = 0x004.
//   Release with no stores -> tx stays 1 for 1000 cycles.
//  Store 0x55 to DATA -> tx=0 one cycle after store for 10 cycles, then bits 1,0,1,0,1,0,1,0
//   each 10 cycles, stop 1.
//   Busy clears 100 cycles after frame start; STATUS=0x004 again.
//  Store 0xA1,0x3C back-to-back -> two contiguous 100-cycle frames, second start bit at cycle 100,
//   decoded bytes match.
//  With TX running, store 17 more bytes -> STATUS shows full=1, count=16, overflow=1.
//   The 17th byte is never sent. Next STATUS read shows overflow=0.
//  FIFO full, store on the edge the FSM pops (STOP->START) -> byte accepted, overflow stays 0, count stays 16.
//  Assert rstn=0 mid-DATA bit 3 with 5 bytes queued -> tx=1 immediately.
//   After release STATUS=0x004 and no frame is emitted.

Source files
------------

// File: rtl/uart_tx_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_io_pkg : register map, status bit positions, and FSM state type     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package uart_tx_io_pkg;

   localparam logic [1:0] UART_DATA_OFS = 2'd0;
   localparam logic [1:0] UART_STAT_OFS = 2'd1;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   // Integer division truncates, so the line rate is always at or above BAUD.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_io_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_io_fifo : synchronous-write, show-ahead byte FIFO                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_tx_io_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO may still accept a byte when the head leaves on the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_io : memory-mapped 8N1 UART transmitter with byte FIFO and status   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_tx_io
   import uart_tx_io_pkg::*;
#(
   parameter int CLK_HZ     = 23_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        uart_cs,
   input  logic        io_write,
   input  logic        io_read,
   input  logic [1:0]  addr_lo,
   input  logic [7:0]  wdata,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int DIV = baud_div(CLK_HZ, BAUD);
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   tx_state_e     state;
   tx_state_e     state_nx;
   logic [BW-1:0] baud_cnt;
   logic [BW-1:0] baud_cnt_nx;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nx;
   logic [7:0]    shift;
   logic [7:0]    shift_nx;
   logic          tx_nx;
   logic          overflow;

   logic          data_wr;
   logic          stat_rd;
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          bit_done;

   assign data_wr  = uart_cs & io_write & (addr_lo == UART_DATA_OFS);
   assign stat_rd  = uart_cs & io_read  & (addr_lo == UART_STAT_OFS);
   assign bit_done = (baud_cnt == BW'(DIV - 1));

   uart_tx_io_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (data_wr),
      .pop   (fifo_pop),
      .din   (wdata),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         tx       <= tx_nx;
         // A drop on the clearing read's edge must not be lost.
         if (data_wr && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end else if (stat_rd) begin
            overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      tx_nx       = tx;
      fifo_pop    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               shift_nx    = fifo_dout;
               tx_nx       = 1'b0;
               baud_cnt_nx = '0;
               state_nx    = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               baud_cnt_nx = '0;
               bit_idx_nx  = 3'd0;
               tx_nx       = shift[0];
               shift_nx    = {1'b0, shift[7:1]};
               state_nx    = S_DATA;
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               baud_cnt_nx = '0;
               if (bit_idx == 3'd7) begin
                  tx_nx    = 1'b1;
                  state_nx = S_STOP;
               end else begin
                  tx_nx      = shift[0];
                  shift_nx   = {1'b0, shift[7:1]};
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               baud_cnt_nx = '0;
               // Chain straight into the next start bit so frames stay contiguous.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_nx = fifo_dout;
                  tx_nx    = 1'b0;
                  state_nx = S_START;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rdata = '0;
      if (addr_lo == UART_STAT_OFS) begin
         rdata[STAT_BUSY]            = (state != S_IDLE);
         rdata[STAT_FULL]            = fifo_full;
         rdata[STAT_EMPTY]           = fifo_empty;
         rdata[STAT_OVF]             = overflow;
         rdata[STAT_CNT_LSB +: CW]   = fifo_count;
      end
   end

endmodule
`default_nettype wire
